piece_bag_generator: RTL

PIECE_BAG_GENERATOR -- requirements
Module: piece_bag_generator

---
 rtl/tetris_pkg.sv | 27 ++
 rtl/lfsr_core.sv | 51 +++++
 rtl/piece_bag_generator.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared shape definitions for the piece generator.
// Holds the shape count, the shape code width and the code assigned to
// each tetromino.
package tetris_pkg;

  localparam int NUM_SHAPES = 7;
  localparam int SHAPE_W    = $clog2(NUM_SHAPES);

  typedef enum logic [SHAPE_W-1:0] {
    SHAPE_I = 3'd0,
    SHAPE_O = 3'd1,
    SHAPE_T = 3'd2,
    SHAPE_S = 3'd3,
    SHAPE_Z = 3'd4,
    SHAPE_J = 3'd5,
    SHAPE_L = 3'd6
  } shape_e;

  localparam logic [SHAPE_W-1:0] CODE_I = SHAPE_I;
  localparam logic [SHAPE_W-1:0] CODE_O = SHAPE_O;
  localparam logic [SHAPE_W-1:0] CODE_T = SHAPE_T;
  localparam logic [SHAPE_W-1:0] CODE_S = SHAPE_S;
  localparam logic [SHAPE_W-1:0] CODE_Z = SHAPE_Z;
  localparam logic [SHAPE_W-1:0] CODE_J = SHAPE_J;
  localparam logic [SHAPE_W-1:0] CODE_L = SHAPE_L;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR that shifts left every cycle outside reset.
// Ports:
//   clock      - rising-edge clock
//   resetn     - asynchronous active-low reset, loads SEED (1 if SEED is 0)
//   load       - replace the register with load_value this edge
//   load_value - value to load; a zero value loads 1 instead
//   value      - low OUT_W bits of the register
module lfsr_core #(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = 16'hABCD,
  parameter int                OUT_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [OUT_W-1:0] value
);

  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic             feedback;

  always_comb begin
    feedback = ^(state & TAPS);
    if (load) begin
      state_next = (load_value == '0) ? ONE : load_value;
    end else begin
      state_next = {state[WIDTH-2:0], feedback};
    end
    // The all-zero state is a lock-up point for an XOR LFSR; never enter it.
    if (state_next == '0) begin
      state_next = ONE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RESET_VALUE;
    end else begin
      state <= state_next;
    end
  end

  assign value = state[OUT_W-1:0];

endmodule

// File: rtl/piece_bag_generator.sv
// Random shape generator with a current-shape register and a preview queue.
// An LFSR offers one candidate code per cycle; legal candidates (and, in bag
// mode, ones not yet drawn from the current bag) enter a small FIFO whose
// head is the current shape and whose remaining slots form the preview.
// Ports:
//   clock         - rising-edge clock
//   resetn        - asynchronous active-low reset
//   seed_load     - one-cycle reseed request, empties queue and bag
//   seed_in       - seed used on seed_load (0 is replaced by 1)
//   next_req      - pop the current shape (ignored while shape_valid is 0)
//   shape_valid   - shape_id holds a legal shape
//   shape_id      - current shape code
//   preview       - upcoming shapes, slot 0 (next) in the LSBs
//   preview_valid - one valid bit per preview slot
module piece_bag_generator #(
  parameter int                     LFSR_WIDTH    = 16,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_TAPS     = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0]  INITIAL_SEED  = 16'hABCD,
  parameter int                     NUM_SHAPES    = tetris_pkg::NUM_SHAPES,
  parameter int                     PREVIEW_DEPTH = 3,
  parameter int                     BAG_MODE      = 1,
  localparam int                    SHAPE_W       = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             seed_load,
  input  logic [LFSR_WIDTH-1:0]            seed_in,
  input  logic                             next_req,
  output logic                             shape_valid,
  output logic [SHAPE_W-1:0]               shape_id,
  output logic [SHAPE_W*PREVIEW_DEPTH-1:0] preview,
  output logic [PREVIEW_DEPTH-1:0]         preview_valid
);

  localparam int QDEPTH = PREVIEW_DEPTH + 1;

  logic [SHAPE_W-1:0]    candidate;
  logic [NUM_SHAPES-1:0] cand_onehot;
  logic                  cand_legal;
  logic                  cand_in_bag;
  logic                  cand_accept;
  logic                  pop;
  logic                  q_full;
  logic                  do_write;

  // Queue storage. q_vld is a thermometer code (slot 0 fills first) and
  // slots beyond it always hold zero, so the outputs need no masking.
  logic [SHAPE_W-1:0]    q_data      [QDEPTH];
  logic [SHAPE_W-1:0]    q_data_next [QDEPTH];
  logic [SHAPE_W-1:0]    sh_data     [QDEPTH];
  logic [QDEPTH-1:0]     q_vld;
  logic [QDEPTH-1:0]     q_vld_next;
  logic [QDEPTH-1:0]     sh_vld;
  logic [QDEPTH-1:0]     slot_open;

  logic [NUM_SHAPES-1:0] bag_used;
  logic [NUM_SHAPES-1:0] bag_next;

  lfsr_core #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (INITIAL_SEED),
    .OUT_W (SHAPE_W)
  ) u_lfsr (
    .clock      (clock),
    .resetn     (resetn),
    .load       (seed_load),
    .load_value (seed_in),
    .value      (candidate)
  );

  // Candidate screening. The one-hot decode stays all-zero for codes
  // outside 0..NUM_SHAPES-1, which keeps the bag lookup in range.
  always_comb begin
    cand_onehot = '0;
    for (int i = 0; i < NUM_SHAPES; i++) begin
      if (candidate == SHAPE_W'(i)) begin
        cand_onehot[i] = 1'b1;
      end
    end
    cand_legal  = (int'(candidate) < NUM_SHAPES);
    cand_in_bag = |(cand_onehot & bag_used);
    cand_accept = cand_legal && !((BAG_MODE != 0) && cand_in_bag);
  end

  assign pop      = next_req && q_vld[0];
  assign q_full   = q_vld[QDEPTH-1];
  assign do_write = !seed_load && cand_accept && (!q_full || pop);

  // Shift first, then append into the first empty slot of the shifted
  // queue; a pop on a full queue therefore frees the last slot for the write.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      sh_data[i] = q_data[i];
    end
    sh_vld = q_vld;
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        sh_data[i] = q_data[i+1];
      end
      sh_data[QDEPTH-1] = '0;
      sh_vld = {1'b0, q_vld[QDEPTH-1:1]};
    end

    slot_open = ~sh_vld & {sh_vld[QDEPTH-2:0], 1'b1};

    q_data_next = sh_data;
    q_vld_next  = sh_vld;
    if (do_write) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (slot_open[i]) begin
          q_data_next[i] = candidate;
          q_vld_next[i]  = 1'b1;
        end
      end
    end

    if (seed_load) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_data_next[i] = '0;
      end
      q_vld_next = '0;
    end
  end

  // Bag bookkeeping: the write that completes the bag starts a fresh one.
  always_comb begin
    bag_next = bag_used;
    if ((BAG_MODE != 0) && do_write) begin
      bag_next = bag_used | cand_onehot;
      if (&bag_next) begin
        bag_next = '0;
      end
    end
    if (seed_load) begin
      bag_next = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
      end
      q_vld    <= '0;
      bag_used <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= q_data_next[i];
      end
      q_vld    <= q_vld_next;
      bag_used <= bag_next;
    end
  end

  assign shape_id      = q_data[0];
  assign shape_valid   = q_vld[0];
  assign preview_valid = q_vld[QDEPTH-1:1];

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
    assign preview[g*SHAPE_W +: SHAPE_W] = q_data[g+1];
  end

endmodule
